// File: rtl/distributor.sv
// -----------------------------------------------------------------------------
// distributor
//
// Single-input, N-output word distributor. Words arrive on one req/ack channel,
// are buffered in a small FIFO, and are steered to the output selected by the
// destination field in the word's top SELW bits. Words addressed to an output
// that does not exist are discarded and counted.
//
// Ports:
//   clk         in   1     rising-edge clock
//   reset       in   1     synchronous, active-high reset
//   req_in      in   1     input word valid
//   ack_in      out  1     distributor can accept a word (FIFO not full)
//   data_in     in   DW    input word
//   reqs_out    out  N     one-hot output request (registered)
//   acks_out    in   N     per-output acknowledge
//   data_out    out  DW    word being offered, shared by all outputs
//   selected    out  SELW  index of output currently or last driven
//   drop_count  out  8     saturating count of discarded words
// -----------------------------------------------------------------------------
module distributor #(
    parameter int N     = 5,
    parameter int DW    = 8,
    parameter int SELW  = 3,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_in,
    output logic            ack_in,
    input  logic [DW-1:0]   data_in,
    output logic [N-1:0]    reqs_out,
    input  logic [N-1:0]    acks_out,
    output logic [DW-1:0]   data_out,
    output logic [SELW-1:0] selected,
    output logic [7:0]      drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [SELW:0] N_EXT    = (SELW+1)'(N);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Full blocks the push even if a pop frees a slot on the same edge;
    // reset also closes the input so nothing lands in a FIFO being cleared.
    assign ack_in = !fifo_full && !reset;
    assign push   = req_in && ack_in;

    // NOTE: storage is not reset; an entry is only ever read while count
    // says it holds a word, so clearing pointers and count is sufficient.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH on its own.
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    logic [DW-1:0]   head;
    logic [SELW-1:0] head_dest;
    logic            head_ok;

    assign head      = mem_q[rptr_q];
    assign head_dest = head[DW-1 -: SELW];
    assign head_ok   = !fifo_empty && ({1'b0, head_dest} < N_EXT);

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [N-1:0]    reqs_q, reqs_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [7:0]      drop_q, drop_d;

    logic            ack_sel;
    logic            load;
    logic            drop;
    logic            clear;

    // reqs_q is one-hot on the selected output while sending, so masking
    // with it picks that output's ack and ignores every other one.
    assign ack_sel = |(acks_out & reqs_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (head_ok) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ack_sel && !head_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        load  = 1'b0;
        drop  = 1'b0;
        clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    load = head_ok;
                    drop = !head_ok;
                end
            end
            SEND: begin
                if (ack_sel) begin
                    // A valid head is chained in with no idle cycle; an
                    // invalid one is left for IDLE to drop.
                    pop   = head_ok;
                    load  = head_ok;
                    clear = !head_ok;
                end
            end
            default: ;
        endcase

        reqs_d = reqs_q;
        data_d = data_q;
        sel_d  = sel_q;
        if (load) begin
            reqs_d = N'(1) << head_dest;
            data_d = head;
            sel_d  = head_dest;
        end else if (clear) begin
            reqs_d = '0;
        end

        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reqs_q <= '0;
            data_q <= '0;
            sel_q  <= '0;
            drop_q <= '0;
        end else begin
            reqs_q <= reqs_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            drop_q <= drop_d;
        end
    end

    assign reqs_out   = reqs_q;
    assign data_out   = data_q;
    assign selected   = sel_q;
    assign drop_count = drop_q;

endmodule

// File: doc/distributor.md
# distributor

Single-input, N-output packet distributor: the counterpart of the N-to-1 arbiter. It accepts words from one req/ack channel, such as the arbiter's output or an emitter, and buffers them in a small FIFO. It steers each word to one output channel chosen by a destination field in the word's top bits. Words addressed to a non-existent output are discarded and counted.

## Interface
- N, 5, number of output channels (2..8)
- DW, 8, data word width
- SELW, 3, destination field width; field = data[DW-1 -: SELW]; need 2^SELW >= N
- DEPTH, 2, input FIFO depth (power of two, >= 2)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_in  in  1  input word valid
- ack_in  out  1  distributor can accept a word
- data_in  in  DW  input word
- reqs_out  out  N  one-hot output request (registered)
- acks_out  in  N  per-output acknowledge
- data_out  out  DW  word being offered; shared by all outputs, full word including header
- selected  out  SELW  index of output currently or last driven
- drop_count  out  8  saturating count of discarded words

## Operation
- Handshake, both sides: a transfer occurs on any rising edge where req and ack are both 1. The sender holds the word and req stable until that edge.
- Input: ack_in = !fifo_full, forced to 0 while reset = 1.
  - When full, no push occurs, even if a pop happens on the same edge.
  - Push and pop on the same edge when not full: count unchanged.
- The FIFO has DEPTH entries with read and write pointers and a count. Pointers wrap modulo DEPTH.
- FSM state IDLE (reqs_out = 0):
  - FIFO empty: stay in IDLE.
  - Head destination d < N: pop, load data_out = head, selected = d, reqs_out = 1<<d, go to SEND.
  - Head destination d >= N: pop, drop_count += 1 (saturates at 255), stay in IDLE. Outputs are unchanged.
- FSM state SEND: hold reqs_out, data_out and selected stable.
  - acks_out[selected] = 0: stay in SEND.
  - acks_out[selected] = 1, FIFO head valid (d < N): pop and load that word directly with no idle cycle. Stay in SEND.
  - acks_out[selected] = 1, head invalid (d >= N) or FIFO empty: reqs_out = 0, go to IDLE. An invalid head is dropped on a later IDLE cycle.
- Acks on unselected outputs are ignored in every state.
- Order is preserved: words leave in arrival order across all outputs.

## Timing
- Reset values: reqs_out = 0, data_out = 0, selected = 0, drop_count = 0, FIFO empty, state IDLE. ack_in = 0 during reset and 1 on the first cycle after it.
- Latency: a word pushed at edge t into an empty FIFO, with the FSM in IDLE, raises reqs_out after edge t+1.
- Throughput: with acks_out held high and req_in continuous, one word per cycle after the first.
- A drop occupies one IDLE cycle per invalid word.
- Reset asserted mid-transfer: at the next edge all FIFO contents are discarded, reqs_out drops to 0 and drop_count clears. No partial transfer completes on that edge.
- A full FIFO with SEND blocked holds ack_in = 0 indefinitely (no deadlock, no data loss).
- drop_count stays at 255 once saturated.

## Test plan
- Reset then single word: push 0x45 (dest 2) -> ack_in = 1 at push. reqs_out = 5'b00100, data_out = 0x45, selected = 2 one cycle later. Drops to 0 the cycle after acks_out[2] = 1.
- Back-to-back: push 0x05, 0x25, 0x85 (dests 0, 1, 4) with acks_out = 5'b11111 -> reqs_out = 00001, 00010, 10000 on consecutive cycles, then 0.
- Backpressure: acks_out = 0, push 3 words with DEPTH = 2 -> 1st in SEND, 2nd and 3rd fill FIFO, ack_in = 0. 4th word not accepted until an ack frees space. Order preserved.
- Invalid destination: push 0xC1 (dest 6), then 0x21 -> 0xC1 never appears on reqs_out. drop_count = 1. 0x21 delivered on output 1.
- Wrong-output ack: SEND on output 3, acks_out = 5'b00100 -> reqs_out stays 01000 and the word is held. Setting acks_out[3] then completes the transfer.
- Reset mid-operation: FIFO full plus SEND active, reset for 1 cycle -> next edge reqs_out = 0, drop_count = 0, ack_in = 1 after release. No stale word is ever offered.
